// File: rtl/noc_pkg.sv
// Shared NOC router types: flit/lane/select widths, lane select type, merge-arbiter states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package noc_pkg;

  localparam int NOC_FLIT_W = 16;
  localparam int NOC_LANES  = 4;
  localparam int NOC_SEL_W  = 2;

  // Lane index; same encoding as the demux sel_i.
  typedef logic [NOC_SEL_W-1:0] noc_sel_t;

  // Merge arbiter: IDLE arbitrates between lanes, LOCKED follows one lane until its tail.
  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } noc_arb_state_t;

  // Next lane after s, wrapping modulo the lane count.
  function automatic noc_sel_t noc_sel_next(input noc_sel_t s);
    return s + noc_sel_t'(1);
  endfunction

endpackage

// File: rtl/noc_rr_arbiter4.sv
// Combinational 4-way round-robin pick: first requesting lane at or after ptr.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the caller decides whether the pick is granted.
module noc_rr_arbiter4
  import noc_pkg::*;
(
  input  logic [3:0] req,
  input  noc_sel_t   ptr,
  output noc_sel_t   grant,
  output logic       any_req
);

  noc_sel_t idx;

  // Scan from the farthest offset down so the nearest requester at or after ptr wins.
  always_comb begin
    grant   = ptr;
    idx     = ptr;
    any_req = |req;
    for (int i = NOC_LANES - 1; i >= 0; i--) begin
      idx = ptr + noc_sel_t'(i);
      if (req[idx]) grant = idx;
    end
  end

endmodule

// File: rtl/noc_arb_mux_4to1.sv
// NOC merge: 4 lanes round-robin onto one link, packet-locked, registered output slice.
// Latency: 1 cycle from input accept to valid_o; 1 flit/cycle with ready_i high.
// Backpressure: held output with ready_i low drops all ready_o; optional NOC_ARB_MUX_STATS_EN adds pkt_cnt_o.
module noc_arb_mux_4to1
  import noc_pkg::*;
#(
  parameter int DATA_W = NOC_FLIT_W
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic [4*DATA_W-1:0]   data_i,
  input  logic [3:0]            valid_i,
  input  logic [3:0]            last_i,
  output logic [3:0]            ready_o,
  output logic [DATA_W-1:0]     data_o,
  output logic                  valid_o,
  output logic                  last_o,
  output noc_sel_t              src_o,
  input  logic                  ready_i
`ifdef NOC_ARB_MUX_STATS_EN
  ,
  output logic [4*16-1:0]       pkt_cnt_o
`endif
);

  noc_arb_state_t    state;
  noc_sel_t          rr_ptr;
  noc_sel_t          owner;
  noc_sel_t          pick;
  noc_sel_t          gnt_lane;
  logic              any_req;
  logic              load_ok;
  logic              rdy_en;
  logic              accept;
  logic              gnt_last;
  logic [DATA_W-1:0] gnt_dat;

  noc_rr_arbiter4 u_arb (
    .req     (valid_i),
    .ptr     (rr_ptr),
    .grant   (pick),
    .any_req (any_req)
  );

  // Output slice can take a new flit when empty or being drained this cycle.
  assign load_ok = !valid_o || ready_i;

  // Choose the lane offered ready: the lock owner while locked, else the round-robin pick.
  always_comb begin
    gnt_lane = owner;
    rdy_en   = 1'b0;
    if (state == LOCKED) begin
      rdy_en = 1'b1;
    end else begin
      gnt_lane = pick;
      rdy_en   = any_req;
    end
    rdy_en = rdy_en && load_ok && rst_n_i;
  end

  assign ready_o  = rdy_en ? (4'b0001 << gnt_lane) : 4'b0000;
  assign accept   = rdy_en && valid_i[gnt_lane];
  assign gnt_last = last_i[gnt_lane];
  assign gnt_dat  = data_i[gnt_lane*DATA_W +: DATA_W];

  // Lock FSM, round-robin pointer and registered output slice.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state   <= IDLE;
      rr_ptr  <= '0;
      owner   <= '0;
      valid_o <= 1'b0;
      data_o  <= '0;
      last_o  <= 1'b0;
      src_o   <= '0;
    end else if (accept) begin
      valid_o <= 1'b1;
      data_o  <= gnt_dat;
      last_o  <= gnt_last;
      src_o   <= gnt_lane;
      if (gnt_last) begin
        state  <= IDLE;
        rr_ptr <= noc_sel_next(gnt_lane);
      end else begin
        state  <= LOCKED;
        owner  <= gnt_lane;
      end
    end else if (ready_i) begin
      // Flit drained with nothing to replace it; payload fields hold their last value.
      valid_o <= 1'b0;
    end
  end

`ifdef NOC_ARB_MUX_STATS_EN
  // Per-lane count of accepted tail flits, saturating.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      pkt_cnt_o <= '0;
    end else if (accept && gnt_last) begin
      for (int k = 0; k < NOC_LANES; k++) begin
        if (gnt_lane == noc_sel_t'(k) && pkt_cnt_o[k*16 +: 16] != 16'hFFFF) begin
          pkt_cnt_o[k*16 +: 16] <= pkt_cnt_o[k*16 +: 16] + 16'd1;
        end
      end
    end
  end
`endif

endmodule
